// File: rtl/dec_2to4_pulse_if.sv
// dec_2to4_pulse_if: ready/valid request channel carrying the encoder's {q, v} code
interface dec_2to4_pulse_if;
   logic       in_valid;
   logic       in_ready;
   logic [1:0] q;
   logic       v;
   modport master (output in_valid, q, v, input in_ready);
   modport slave (input in_valid, q, v, output in_ready);
endinterface

// File: rtl/dec_2to4_pulse.sv
// dec_2to4_pulse: sequenced 2-to-4 decoder, drives one line for HOLD cycles then idles GAP cycles
module dec_2to4_pulse #(
   parameter int HOLD = 4,
   parameter int GAP = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   dec_2to4_pulse_if.slave  s,
   output logic [3:0]       d,
   output logic             active,
   output logic             done
);
   typedef enum logic [1:0] {st_idle, st_drive, st_gap} state_t;
   localparam logic [7:0] hold_ld = 8'(HOLD - 1);
   localparam logic [7:0] gap_ld = GAP > 0 ? 8'(GAP - 1) : 8'd0;
   state_t     state, state_n;
   logic [7:0] cnt, cnt_n;
   logic [3:0] d_n;
   logic       done_n, rdy, rdy_n, xfer, last, take;
   assign xfer = s.in_valid && rdy;
   assign take = state == st_idle && xfer && s.v;
   assign last = cnt == 8'd0;
   assign s.in_ready = rdy;
   assign active = |d;
   // ready is registered so it stays low until the first edge after reset release
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= st_idle;
         cnt   <= 8'd0;
         d     <= 4'b0000;
         done  <= 1'b0;
         rdy   <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         d     <= d_n;
         done  <= done_n;
         rdy   <= rdy_n;
      end
   always_comb begin
      state_n = state;
      cnt_n   = last ? 8'd0 : cnt - 8'd1;
      if (take) begin
         state_n = st_drive;
         cnt_n   = hold_ld;
      end else if (state == st_drive && last) begin
         state_n = GAP > 0 ? st_gap : st_idle;
         cnt_n   = gap_ld;
      end else if (state == st_gap && last)
         state_n = st_idle;
   end
   always_comb begin
      d_n    = take ? 4'b0001 << s.q : (state == st_drive && !last) ? d : 4'b0000;
      done_n = state == st_drive && last;
      rdy_n  = state_n == st_idle;
   end
endmodule

// File: tb/tb_dec_2to4_pulse.sv
// tb_dec_2to4_pulse: vector table, directed sequences and random stimulus against a timing model
module tb_dec_2to4_pulse;
   localparam int H = 4;
   localparam int G = 1;
   typedef struct {
      logic       vld;
      logic [1:0] q;
      logic       v;
      logic [3:0] d;
      logic       done;
      logic       rdy;
   } vec_t;
   vec_t tbl[12];
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_a = 1'b1, rst_b = 1'b1;
   logic [3:0] d_a, d_b;
   logic active_a, active_b, done_a, done_b;
   dec_2to4_pulse_if ia();
   dec_2to4_pulse_if ib();
   dec_2to4_pulse #(.HOLD(H), .GAP(G)) ua (.clk(clk), .rst_n(rst_a), .s(ia), .d(d_a), .active(active_a), .done(done_a));
   dec_2to4_pulse #(.HOLD(1), .GAP(0)) ub (.clk(clk), .rst_n(rst_b), .s(ib), .d(d_b), .active(active_b), .done(done_b));
   int total = 0, bad = 0;
   // model state: edges since the last v=1 accept, edges since reset release, accepted line
   int a_since = 1000, a_up = 0;
   logic [1:0] a_ql = 2'd0;
   function automatic logic [3:0] m_d(int k, logic [1:0] ql);
      return (k >= 1 && k <= H) ? 4'b0001 << ql : 4'b0000;
   endfunction
   function automatic logic m_rdy(int k, int up);
      return up >= 1 && !(k >= 1 && k <= H + G);
   endfunction
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
      end
   endtask
   task automatic tick_a();
      logic x;
      x = ia.in_valid && m_rdy(a_since, a_up);
      @(posedge clk);
      if (!rst_a) begin
         a_since = 1000;
         a_up = 0;
      end else begin
         a_up++;
         if (x && ia.v) begin
            a_since = 1;
            a_ql = ia.q;
         end else if (a_since < 1000) a_since++;
      end
      #1;
      chk("a_d", d_a, m_d(a_since, a_ql));
      chk("a_active", active_a, |m_d(a_since, a_ql));
      chk("a_done", done_a, a_since == H + 1);
      chk("a_ready", ia.in_ready, m_rdy(a_since, a_up));
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end
   initial begin
      int hold, lowr, dn, idx, cyc, last_acc;
      int qs[3] = '{3, 0, 1};
      tbl[0]  = '{1'b1, 2'd0, 1'b1, 4'b0000, 1'b0, 1'b1};
      tbl[1]  = '{1'b1, 2'd0, 1'b1, 4'b0001, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 2'd1, 1'b1, 4'b0000, 1'b1, 1'b1};
      tbl[3]  = '{1'b1, 2'd1, 1'b1, 4'b0010, 1'b0, 1'b0};
      tbl[4]  = '{1'b1, 2'd2, 1'b1, 4'b0000, 1'b1, 1'b1};
      tbl[5]  = '{1'b1, 2'd2, 1'b1, 4'b0100, 1'b0, 1'b0};
      tbl[6]  = '{1'b1, 2'd3, 1'b1, 4'b0000, 1'b1, 1'b1};
      tbl[7]  = '{1'b1, 2'd3, 1'b1, 4'b1000, 1'b0, 1'b0};
      tbl[8]  = '{1'b0, 2'd0, 1'b0, 4'b0000, 1'b1, 1'b1};
      tbl[9]  = '{1'b0, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b1};
      tbl[10] = '{1'b1, 2'd3, 1'b0, 4'b0000, 1'b0, 1'b1};
      tbl[11] = '{1'b1, 2'd3, 1'b0, 4'b0000, 1'b0, 1'b1};
      ia.in_valid = 1'b0; ia.q = 2'd0; ia.v = 1'b0;
      ib.in_valid = 1'b0; ib.q = 2'd0; ib.v = 1'b0;
      #2 rst_a = 1'b0; rst_b = 1'b0;
      #1;
      chk("rst_d", d_a, 4'b0000);
      chk("rst_done", done_a, 1'b0);
      chk("rst_ready", ia.in_ready, 1'b0);
      chk("rst_b_ready", ib.in_ready, 1'b0);
      tick_a();
      tick_a();
      #1 rst_a = 1'b1;
      tick_a();
      chk("ready_after_release", ia.in_ready, 1'b1);
      ia.in_valid = 1'b1; ia.q = 2'd2; ia.v = 1'b1;
      tick_a();
      ia.in_valid = 1'b0; ia.q = 2'd0;
      hold = 0; lowr = 0; dn = 0;
      for (int i = 0; i < 7; i++) begin
         hold += int'(d_a == 4'b0100);
         lowr += int'(!ia.in_ready);
         dn += int'(done_a);
         tick_a();
      end
      chk("hold_width", hold, 4);
      chk("ready_low_len", lowr, 5);
      chk("done_count", dn, 1);
      ia.in_valid = 1'b1; ia.q = 2'd3; ia.v = 1'b0;
      repeat (4) tick_a();
      ia.in_valid = 1'b1; ia.v = 1'b1;
      idx = 0; cyc = 0; last_acc = 0;
      while (idx < 3 && cyc < 40) begin
         ia.q = ia.in_ready ? 2'(qs[idx]) : 2'($urandom);
         if (ia.in_ready) begin
            if (idx > 0) chk("accept_spacing", cyc - last_acc, 6);
            last_acc = cyc;
            idx++;
         end
         tick_a();
         cyc++;
      end
      chk("stream_accepts", idx, 3);
      ia.in_valid = 1'b0;
      repeat (6) tick_a();
      ia.in_valid = 1'b1; ia.q = 2'd1; ia.v = 1'b1;
      tick_a();
      ia.in_valid = 1'b0;
      tick_a();
      #2 rst_a = 1'b0;
      #1;
      a_since = 1000; a_up = 0;
      chk("async_clr_d", d_a, 4'b0000);
      chk("async_clr_active", active_a, 1'b0);
      chk("async_clr_ready", ia.in_ready, 1'b0);
      tick_a();
      tick_a();
      #1 rst_a = 1'b1;
      tick_a();
      ia.in_valid = 1'b1; ia.q = 2'd0; ia.v = 1'b1;
      tick_a();
      ia.in_valid = 1'b0;
      repeat (6) tick_a();
      repeat (300) begin
         ia.in_valid = 1'($urandom_range(0, 1));
         ia.q = 2'($urandom);
         ia.v = 1'($urandom);
         tick_a();
      end
      #1 rst_b = 1'b1;
      for (int i = 0; i < 12; i++) begin
         ib.in_valid = tbl[i].vld;
         ib.q = tbl[i].q;
         ib.v = tbl[i].v;
         @(posedge clk);
         #1;
         chk("b_d", d_b, tbl[i].d);
         chk("b_active", active_b, |tbl[i].d);
         chk("b_done", done_b, tbl[i].done);
         chk("b_ready", ib.in_ready, tbl[i].rdy);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
